// File: rtl/bitcell_array_ctrl.sv
// Sequencing controller for a ROWS x DATA_W bitcell array: valid/ready request in,
// setup/access/hold pin sequencing out, one-cycle completion pulse with read data.
module bitcell_array_ctrl #(
  parameter int ADDR_W     = 2,
  parameter int DATA_W     = 4,
  parameter int ACC_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  output logic                   rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic [(2**ADDR_W)-1:0] arr_sel,
  output logic                   arr_rw,
  output logic [DATA_W-1:0]      arr_data,
  input  logic [DATA_W-1:0]      arr_out
);

  localparam int ROWS = 2**ADDR_W;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              we_lat;
  logic [ADDR_W-1:0] addr_lat;

  // arr_rw/arr_data double as the latched write controls: they are loaded on
  // accept and only cleared after HOLD, so they never move while sel is high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      we_lat    <= 1'b0;
      addr_lat  <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      arr_sel   <= '0;
      arr_rw    <= 1'b0;
      arr_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            state     <= SETUP;
            req_ready <= 1'b0;
            we_lat    <= req_we;
            addr_lat  <= req_addr;
            arr_rw    <= req_we;
            arr_data  <= req_we ? req_wdata : '0;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          cnt     <= 4'(ACC_CYCLES - 1);
          arr_sel <= ROWS'(1) << addr_lat;
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            state     <= HOLD;
            arr_sel   <= '0;
            rsp_valid <= 1'b1;
            rsp_rdata <= we_lat ? '0 : arr_out;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          arr_rw    <= 1'b0;
          arr_data  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
